// File: rtl/hier_pkg.sv
// Shared types and the round-robin pick helper for the hierarchy upstream collector.
// The entry struct describes the default configuration: a source tag above the payload.
package hier_pkg;

    localparam int HIER_NUM_CHILD  = 5;
    localparam int HIER_DATA_W     = 16;
    localparam int HIER_FIFO_DEPTH = 4;
    localparam int HIER_SRC_W      = (HIER_NUM_CHILD > 2) ? $clog2(HIER_NUM_CHILD) : 1;

    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    typedef struct packed {
        logic [HIER_SRC_W-1:0]  src;
        logic [HIER_DATA_W-1:0] data;
    } entry_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan from the highest offset down so the lowest offset from ptr is the last writer.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int                  num = HIER_NUM_CHILD);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            if (k < num) begin
                cand = (int'(ptr) + k) % num;
                if (valid[cand]) begin
                    res.found = 1'b1;
                    res.idx   = RR_IDX_W'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hier_upstream_collector_fifo.sv
// Small synchronous FIFO holding tagged words on their way to the parent level.
// Pointers wrap naturally because the depth is a power of two.
module hier_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage is cleared on reset so the head reads zero while the FIFO is empty after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hier_upstream_collector.sv
// Fan-in collector: round-robin grant over child ports, tag each word with its source
// index, and buffer toward the parent through hier_sync_fifo.
module hier_upstream_collector
    import hier_pkg::*;
#(
    parameter  int NUM_CHILD  = HIER_NUM_CHILD,
    parameter  int DATA_W     = HIER_DATA_W,
    parameter  int FIFO_DEPTH = HIER_FIFO_DEPTH,
    localparam int SRC_W      = (NUM_CHILD > 2) ? $clog2(NUM_CHILD) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CHILD-1:0]             child_valid,
    input  logic [NUM_CHILD-1:0][DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]             child_ready,
    output logic                             up_valid,
    output logic [DATA_W-1:0]                up_data,
    output logic [SRC_W-1:0]                 up_src,
    input  logic                             up_ready,
    output logic [15:0]                      accept_cnt
);

    localparam int ENTRY_W = SRC_W + DATA_W;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]        accept_cnt_q, accept_cnt_d;
    rr_pick_t           pick;
    logic               pick_ok;
    logic [SRC_W-1:0]   grant_idx;
    logic               push;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] push_entry, head_entry;

    // Grant is held off during reset so no child sees a handshake that will be discarded.
    always_comb begin
        pick        = rr_pick(RR_MAX'(child_valid), RR_IDX_W'(rr_ptr_q), NUM_CHILD);
        pick_ok     = pick.found && (int'(pick.idx) < NUM_CHILD);
        grant_idx   = pick.idx[SRC_W-1:0];
        child_ready = '0;
        if (pick_ok && !fifo_full && !rst) begin
            child_ready[grant_idx] = 1'b1;
        end
        push       = |(child_valid & child_ready);
        push_entry = {grant_idx, child_data[grant_idx]};

        rr_ptr_d     = rr_ptr_q;
        accept_cnt_d = accept_cnt_q;
        if (push) begin
            rr_ptr_d     = (grant_idx == SRC_W'(NUM_CHILD - 1)) ? '0 : grant_idx + SRC_W'(1);
            accept_cnt_d = accept_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            accept_cnt_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    hier_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (up_valid & up_ready),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign up_valid   = ~fifo_empty;
    assign up_src     = head_entry[ENTRY_W-1 -: SRC_W];
    assign up_data    = head_entry[DATA_W-1:0];
    assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_hier_upstream_collector.sv
// Scoreboard bench for hier_upstream_collector: the driver predicts grants and queues
// expected words; an independent monitor pops and compares whenever the parent takes one.
module tb_hier_upstream_collector;
    import hier_pkg::*;

    localparam int N     = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SW    = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             child_valid;
    logic [N-1:0][DW-1:0]     child_data;
    logic [N-1:0]             child_ready;
    logic                     up_valid;
    logic [DW-1:0]            up_data;
    logic [SW-1:0]            up_src;
    logic                     up_ready;
    logic [15:0]              accept_cnt;

    hier_upstream_collector #(
        .NUM_CHILD  (N),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .up_valid    (up_valid),
        .up_data     (up_data),
        .up_src      (up_src),
        .up_ready    (up_ready),
        .accept_cnt  (accept_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    entry_t      exp_q[$];
    int          m_rr;
    int          m_occ;
    int          last_win;
    logic [15:0] m_cnt;
    bit          mon_en;
    int          grant_hist[N];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, then predict the grant from the
    // reference rules (first valid child at or after the pointer, nothing while full).
    task automatic applyStimulus(input logic [N-1:0] vmask, input logic ur);
        int       win;
        int       c;
        entry_t   e;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        if (last_win >= 0) child_data[last_win] = DW'($urandom);
        child_valid = vmask;
        up_ready    = ur;
        #2;
        win = -1;
        if (m_occ < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (win < 0 && vmask[c]) win = c;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        checkOutput("child_ready", 32'(child_ready), 32'(exp_ready));
        checkOutput("accept_cnt", 32'(accept_cnt), 32'(m_cnt));
        for (int k = 0; k < N; k++) if (child_ready[k]) grant_hist[k]++;
        if (ur && m_occ > 0) m_occ--;
        if (win >= 0) begin
            e.src  = SW'(win);
            e.data = child_data[win];
            exp_q.push_back(e);
            m_rr  = (win + 1) % N;
            m_cnt = m_cnt + 16'd1;
            m_occ++;
        end
        last_win = win;
    endtask

    initial begin : monitor
        entry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                checkOutput("up_valid", 32'(up_valid), 32'(exp_q.size() != 0));
                if (up_valid && up_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL pop_order: got a word src=%0d data=0x%0h expected none at %0t",
                                 up_src, up_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("up_src", 32'(up_src), 32'(e.src));
                        checkOutput("up_data", 32'(up_data), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        child_valid = '1;
        for (int c = 0; c < N; c++) child_data[c] = DW'($urandom);
        up_ready = 1'b0;
        mon_en   = 1'b0;
        last_win = -1;
        m_rr     = 0;
        m_occ    = 0;
        m_cnt    = '0;

        #12;
        checkOutput("rst_child_ready", 32'(child_ready), 32'd0);
        checkOutput("rst_up_valid", 32'(up_valid), 32'd0);
        checkOutput("rst_up_data", 32'(up_data), 32'd0);
        checkOutput("rst_up_src", 32'(up_src), 32'd0);
        checkOutput("rst_accept_cnt", 32'(accept_cnt), 32'd0);
        child_valid = '0;
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        $display("[TB] idle");
        repeat (5) applyStimulus('0, 1'b1);

        $display("[TB] single child");
        child_data[3] = 16'hA5A5;
        applyStimulus(5'b01000, 1'b1);
        applyStimulus('0, 1'b1);
        checkOutput("single_cnt", 32'(accept_cnt), 32'd1);

        $display("[TB] fairness");
        foreach (grant_hist[c]) grant_hist[c] = 0;
        repeat (10) applyStimulus('1, 1'b1);
        for (int c = 0; c < N; c++) checkOutput("fair_share", 32'(grant_hist[c]), 32'd2);

        $display("[TB] backpressure");
        repeat (2) applyStimulus('0, 1'b1);
        repeat (6) applyStimulus(5'b00011, 1'b0);
        applyStimulus(5'b00011, 1'b1);
        applyStimulus(5'b00011, 1'b0);
        repeat (8) applyStimulus('0, 1'b1);

        $display("[TB] mid-operation reset");
        repeat (3) applyStimulus(5'b00100, 1'b0);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_up_valid", 32'(up_valid), 32'd0);
        checkOutput("midrst_accept_cnt", 32'(accept_cnt), 32'd0);
        checkOutput("midrst_child_ready", 32'(child_ready), 32'd0);
        child_valid = '0;
        exp_q.delete();
        m_rr     = 0;
        m_occ    = 0;
        m_cnt    = '0;
        last_win = -1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        child_data[0] = 16'h1234;
        child_data[4] = 16'h4444;
        applyStimulus(5'b10001, 1'b1);
        applyStimulus('0, 1'b1);

        $display("[TB] random traffic");
        repeat (2000) begin
            logic [N-1:0] m;
            for (int c = 0; c < N; c++) begin
                if (child_valid[c] && c != last_win) begin
                    m[c] = 1'b1;
                end else begin
                    m[c] = ($urandom_range(0, 99) < 50);
                    if (!child_valid[c]) child_data[c] = DW'($urandom);
                end
            end
            applyStimulus(m, ($urandom_range(0, 99) < 60));
        end

        $display("[TB] counter wrap");
        repeat (6) applyStimulus('0, 1'b1);
        while (m_cnt != 16'hFFFF) applyStimulus(5'b00001, 1'b1);
        applyStimulus('0, 1'b1);
        checkOutput("wrap_pre", 32'(accept_cnt), 32'h0000FFFF);
        applyStimulus(5'b00001, 1'b1);
        applyStimulus('0, 1'b1);
        checkOutput("wrap_post", 32'(accept_cnt), 32'd0);

        repeat (3) applyStimulus('0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hier_upstream_collector.md
# hier_upstream_collector

Fan-in collector for the module hierarchy: gathers words from up to NUM_CHILD child instances through per-child valid/ready ports, arbitrates round-robin, tags each word with its source child index, and buffers them in a small FIFO toward the parent level. It sits at each root/intermediate node and carries traffic child-to-parent, the reverse of the parent-to-child instantiation fan-out.

## Interface
- NUM_CHILD, default 5: number of child ports; legal range 2..16.
- DATA_W, default 16: payload width.
- FIFO_DEPTH, default 4: upstream buffer entries; must be a power of two and at least 2.
- SRC_W, derived as $clog2(NUM_CHILD), minimum 1: width of the source tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- child_valid  in  NUM_CHILD  per-child word available.
- child_data  in  NUM_CHILD x DATA_W  per-child payload.
- child_ready  out  NUM_CHILD  per-child accept; at most one bit high per cycle.
- up_valid  out  1  FIFO head valid.
- up_data  out  DATA_W  FIFO head payload.
- up_src  out  SRC_W  FIFO head source child index.
- up_ready  in  1  parent accepts the head.
- accept_cnt  out  16  total words accepted from children; wraps modulo 2^16.

## Operation
- Grant logic is combinational from child_valid, the round-robin pointer rr_ptr and fifo_full.
  - When fifo_full=0, the first valid child found scanning rr_ptr, rr_ptr+1, … (mod NUM_CHILD) gets child_ready=1.
  - When fifo_full=1, or no child is valid, child_ready is all zero.
- Accept occurs when child_valid[i] & child_ready[i]. On accept:
  - {i, child_data[i]} is written to the FIFO tail.
  - rr_ptr becomes (i+1) mod NUM_CHILD.
  - accept_cnt increments.
- With no accept, rr_ptr holds.
- Pop occurs when up_valid & up_ready; the head advances.
- up_valid equals !fifo_empty. up_data and up_src come straight from the head entry, with no extra register.
- Simultaneous push and pop:
  - When not full, both happen and the occupancy count is unchanged.
  - When full, push is blocked by the grant rule even if a pop happens the same cycle. Occupancy drops by 1 and the grant reopens next cycle.
- Pop with the FIFO empty is impossible, because up_valid=0.
- Child protocol rule: a child holding child_valid=1 must keep its data stable until accepted. The block neither checks nor latches unaccepted data.
- Occupancy count has width $clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous assert; release is used synchronously to clk):
  - rr_ptr=0, FIFO empty, accept_cnt=0.
  - up_valid=0, up_data=0, up_src=0.
  - child_ready=0 for as long as rst is high.
- Latency: a word accepted on cycle N appears on up_* in cycle N+1 if the FIFO was empty, otherwise after the earlier entries drain.
- Throughput: one accept and one pop per cycle, sustained.
- A full FIFO stalls children for exactly the cycles in which fifo_full=1.
- Reset asserted mid-transfer discards all buffered words. No partial state survives.
- accept_cnt 0xFFFF followed by an accept gives 0x0000.

## Structure
- Shared package hier_pkg holds:
  - the entry struct {src, data}, parameterised through localparams;
  - a function rr_pick(valid, ptr) that returns found plus index.
- One sub-module, hier_sync_fifo (DATA_W+SRC_W wide, FIFO_DEPTH deep), with push/pop/full/empty/count. The arbiter and counter stay in the top.

## Test plan
- Reset, then idle: all outputs 0. Set up_ready=1 and drive no child: up_valid stays 0 and accept_cnt stays 0.
- Single child: child 3 sends 0xA5A5 with up_ready=1. Required response: child_ready[3]=1 that cycle; next cycle up_valid=1, up_data=0xA5A5, up_src=3; accept_cnt=1.
- Fairness: all 5 children valid continuously with up_ready=1. Accept order is 0,1,2,3,4,0,…, and 10 cycles give each child exactly 2 accepts.
- Backpressure: up_ready=0 with children 0 and 1 always valid.
  - After 4 accepts the FIFO is full and child_ready=0.
  - Pulse up_ready for 1 cycle: one pop, no push that cycle, and one accept the next cycle.
  - Order out must be 0,1,0,1,…
- Mid-operation reset: fill 3 entries, then assert rst asynchronously between edges. up_valid drops immediately and accept_cnt=0. After release, the first accepted word comes out correctly with rr_ptr restarted at 0.
- Counter wrap: preload via 65535 accepts; the next accept gives accept_cnt=0.
